// File: rtl/ram2_arbiter.sv
// ram2_arbiter
// Shares the single-port 8K x 32 ram2 block RAM between instruction fetch
// (port A) and the load/store unit (port B). At most one access is granted
// per cycle. The winner's address, write data, byte enables and write enable
// drive the RAM combinationally. One-cycle-latency read data is routed back
// to the port that issued the read, together with a valid strobe.
//
// Optional feature macro: RAM2_ARB_RR_EN
//   defined   -> round-robin between A and B using a 1-bit last-grant pointer
//   undefined -> fixed priority, B (load/store) always wins a conflict
//
// Ports
//   clk, tb_rst                    clock (rising edge), async active-high reset
//   a_req/a_we/a_addr/a_wdata/a_be request fields from port A (held until a_gnt)
//   b_req/b_we/b_addr/b_wdata/b_be request fields from port B (held until b_gnt)
//   a_gnt, b_gnt                   request accepted this cycle (combinational)
//   a_rvalid/a_rdata               read return to A (valid the cycle after grant)
//   b_rvalid/b_rdata               read return to B (valid the cycle after grant)
//   ram_addr/ram_wr_data           RAM address / write data
//   ram_wr_byte_en/ram_wr_en       RAM byte enables / write enable
//   ram_rd_data                    RAM read data (one-cycle latency)
module ram2_arbiter #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  tb_rst,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  input  logic [BE_WIDTH-1:0]   a_be,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  input  logic [BE_WIDTH-1:0]   b_be,
  output logic                  a_gnt,
  output logic                  b_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [BE_WIDTH-1:0]   ram_wr_byte_en,
  output logic                  ram_wr_en,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  logic                  grant_a_s;
  logic                  grant_b_s;
  logic                  any_grant_s;
  logic                  rd_grant_s;
  logic [ADDR_WIDTH-1:0] hold_addr_r;
  logic [DATA_WIDTH-1:0] hold_wdata_r;
  logic                  rd_pend_r;
  logic                  rd_owner_r;   // 0 = A, 1 = B

`ifdef RAM2_ARB_RR_EN
  logic                  last_b_r;     // 1 = B was granted most recently

  // Last-grant pointer: remembers which port won the most recent grant
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      last_b_r <= 1'b0;
    end else if (any_grant_s) begin
      last_b_r <= grant_b_s;
    end
  end
`endif

  // Arbitration: at most one winner; nothing is granted while in reset
  always_comb begin
    grant_a_s = 1'b0;
    grant_b_s = 1'b0;
    if (tb_rst) begin
      grant_a_s = 1'b0;
      grant_b_s = 1'b0;
    end else if (a_req && b_req) begin
`ifdef RAM2_ARB_RR_EN
      // The port that did not win last time takes the conflict
      if (last_b_r) begin
        grant_a_s = 1'b1;
      end else begin
        grant_b_s = 1'b1;
      end
`else
      grant_b_s = 1'b1;
`endif
    end else begin
      grant_a_s = a_req;
      grant_b_s = b_req;
    end
  end

  assign a_gnt       = grant_a_s;
  assign b_gnt       = grant_b_s;
  assign any_grant_s = grant_a_s | grant_b_s;
  assign rd_grant_s  = any_grant_s & ~ram_wr_en;

  // RAM drive: winner's fields, or the held copy of the last grant when idle
  always_comb begin
    ram_addr       = hold_addr_r;
    ram_wr_data    = hold_wdata_r;
    ram_wr_byte_en = {BE_WIDTH{1'b0}};
    ram_wr_en      = 1'b0;
    if (grant_b_s) begin
      ram_addr       = b_addr;
      ram_wr_data    = b_wdata;
      ram_wr_en      = b_we;
      ram_wr_byte_en = b_we ? b_be : {BE_WIDTH{1'b0}};
    end else if (grant_a_s) begin
      ram_addr       = a_addr;
      ram_wr_data    = a_wdata;
      ram_wr_en      = a_we;
      ram_wr_byte_en = a_we ? a_be : {BE_WIDTH{1'b0}};
    end else begin
      ram_addr       = hold_addr_r;
      ram_wr_data    = hold_wdata_r;
      ram_wr_byte_en = {BE_WIDTH{1'b0}};
      ram_wr_en      = 1'b0;
    end
  end

  // Held RAM fields and read-owner tracking; reset discards any read in flight
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      hold_addr_r  <= {ADDR_WIDTH{1'b0}};
      hold_wdata_r <= {DATA_WIDTH{1'b0}};
      rd_pend_r    <= 1'b0;
      rd_owner_r   <= 1'b0;
    end else begin
      if (any_grant_s) begin
        hold_addr_r  <= ram_addr;
        hold_wdata_r <= ram_wr_data;
      end
      rd_pend_r <= rd_grant_s;
      if (rd_grant_s) begin
        rd_owner_r <= grant_b_s;
      end
    end
  end

  // Read return: RAM data goes only to the owner of the pending read
  always_comb begin
    a_rvalid = rd_pend_r & ~rd_owner_r;
    b_rvalid = rd_pend_r & rd_owner_r;
    a_rdata  = {DATA_WIDTH{1'b0}};
    b_rdata  = {DATA_WIDTH{1'b0}};
    if (a_rvalid) begin
      a_rdata = ram_rd_data;
    end else begin
      a_rdata = {DATA_WIDTH{1'b0}};
    end
    if (b_rvalid) begin
      b_rdata = ram_rd_data;
    end else begin
      b_rdata = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_ram2_arbiter.sv
// Testbench for ram2_arbiter: behavioural ram2 model, reference arbitration
// model, shadow memory and per-port read-return queues.
module tb_ram2_arbiter;

  logic        clk;
  logic        tb_rst;
  logic        a_req, a_we, b_req, b_we;
  logic [12:0] a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic [3:0]  a_be, b_be;
  logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [31:0] a_rdata, b_rdata;
  logic [12:0] ram_addr;
  logic [31:0] ram_wr_data;
  logic [3:0]  ram_wr_byte_en;
  logic        ram_wr_en;
  logic [31:0] ram_rd_data;

  int vectors;
  int miscompares;

  logic [31:0] ram_mem [0:8191];
  logic [31:0] shadow  [0:8191];
  logic [31:0] q_a [$];
  logic [31:0] q_b [$];
  logic [12:0] last_addr_m;
  logic        ptr_b_m;

  ram2_arbiter dut (
    .clk(clk), .tb_rst(tb_rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
    .a_gnt(a_gnt), .b_gnt(b_gnt),
    .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .ram_addr(ram_addr), .ram_wr_data(ram_wr_data),
    .ram_wr_byte_en(ram_wr_byte_en), .ram_wr_en(ram_wr_en),
    .ram_rd_data(ram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ram2: byte-enabled write, registered read (latency 1)
  always @(posedge clk) begin
    if (ram_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (ram_wr_byte_en[k]) ram_mem[ram_addr][8*k +: 8] <= ram_wr_data[8*k +: 8];
      end
    end
    ram_rd_data <= ram_mem[ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic set_a(input logic req, input logic we, input logic [12:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    a_req = req; a_we = we; a_addr = addr; a_wdata = wd; a_be = be;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [12:0] addr,
                       input logic [31:0] wd, input logic [3:0] be);
    b_req = req; b_we = we; b_addr = addr; b_wdata = wd; b_be = be;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
    set_b(1'b0, 1'b0, 13'h0, 32'h0, 4'h0);
  endtask

  // One clock cycle: compare at the falling edge, update models, return at posedge+1
  task automatic tick();
    logic        ga, gb, eav, ebv, e_we;
    logic [31:0] ea, eb, e_wd;
    logic [12:0] e_addr;
    logic [3:0]  e_be;
    @(negedge clk);
    if (tb_rst) begin
      q_a.delete(); q_b.delete();
      last_addr_m = 13'h0;
      ptr_b_m     = 1'b0;
    end
    eav = (q_a.size() > 0);
    ebv = (q_b.size() > 0);
    ea  = eav ? q_a.pop_front() : 32'h0;
    eb  = ebv ? q_b.pop_front() : 32'h0;
    check("a_rvalid", 32'(a_rvalid), 32'(eav));
    check("b_rvalid", 32'(b_rvalid), 32'(ebv));
    check("a_rdata", a_rdata, ea);
    check("b_rdata", b_rdata, eb);

    ga = 1'b0; gb = 1'b0;
    if (tb_rst) begin
      ga = 1'b0; gb = 1'b0;
    end else if (a_req && b_req) begin
`ifdef RAM2_ARB_RR_EN
      gb = ~ptr_b_m; ga = ptr_b_m;
`else
      gb = 1'b1;
`endif
    end else begin
      ga = a_req; gb = b_req;
    end
    check("a_gnt", 32'(a_gnt), 32'(ga));
    check("b_gnt", 32'(b_gnt), 32'(gb));

    if (ga || gb) begin
      e_addr = gb ? b_addr : a_addr;
      e_we   = gb ? b_we : a_we;
      e_wd   = gb ? b_wdata : a_wdata;
      e_be   = e_we ? (gb ? b_be : a_be) : 4'h0;
    end else begin
      e_addr = last_addr_m; e_we = 1'b0; e_wd = 32'h0; e_be = 4'h0;
    end
    check("ram_addr", 32'(ram_addr), 32'(e_addr));
    check("ram_wr_en", 32'(ram_wr_en), 32'(e_we));
    check("ram_wr_byte_en", 32'(ram_wr_byte_en), 32'(e_be));
    if (tb_rst) check("ram_wr_data_rst", ram_wr_data, 32'h0);
    else if (e_we) check("ram_wr_data", ram_wr_data, e_wd);

    if (ga || gb) begin
      last_addr_m = e_addr;
      ptr_b_m     = gb;
      if (e_we) begin
        for (int k = 0; k < 4; k++) begin
          if (e_be[k]) shadow[e_addr][8*k +: 8] = e_wd[8*k +: 8];
        end
      end else if (gb) begin
        q_b.push_back(shadow[e_addr]);
      end else begin
        q_a.push_back(shadow[e_addr]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    last_addr_m = 13'h0; ptr_b_m = 1'b0;
    for (int i = 0; i < 8192; i++) begin
      ram_mem[i] = 32'h0;
      shadow[i]  = 32'h0;
    end
    ram_rd_data = 32'h0;
    tb_rst = 1'b1;
    idle();
    // Requests during reset must not be granted
    a_req = 1'b1; b_req = 1'b1;
    tick(); tick();
    idle();
    tb_rst = 1'b0;
    tick();

    // A full-word write then read back
    set_a(1'b1, 1'b1, 13'h0005, 32'hDEADBEEF, 4'hF); tick();
    set_a(1'b1, 1'b0, 13'h0005, 32'h0, 4'h0); tick();
    idle(); tick(); tick();

    // B byte write over all-ones, read back, A write in the cycle after the read
    set_b(1'b1, 1'b1, 13'h1FFF, 32'hFFFFFFFF, 4'hF); tick();
    set_b(1'b1, 1'b1, 13'h1FFF, 32'h11223344, 4'b0101); tick();
    set_b(1'b1, 1'b0, 13'h1FFF, 32'h0, 4'h0); tick();
    idle();
    set_a(1'b1, 1'b1, 13'h1FFF, 32'h0BADC0DE, 4'hF); tick();
    idle(); tick();

    // Simultaneous reads for four cycles
    set_a(1'b1, 1'b1, 13'h0010, 32'hA5A50010, 4'hF); tick();
    set_a(1'b1, 1'b1, 13'h0020, 32'h5A5A0020, 4'hF); tick();
    set_a(1'b1, 1'b0, 13'h0010, 32'h0, 4'h0);
    set_b(1'b1, 1'b0, 13'h0020, 32'h0, 4'h0);
    repeat (4) tick();
    idle(); tick();

    // Back-to-back A reads at full rate
    for (int i = 0; i < 8; i++) begin
      set_a(1'b1, 1'b1, 13'(i), 32'h1000_0000 + 32'(i * 17), 4'hF); tick();
    end
    for (int i = 0; i < 8; i++) begin
      set_a(1'b1, 1'b0, 13'(i), 32'h0, 4'h0); tick();
    end
    idle(); tick();

    // Reset the cycle after a B read grant: the read is discarded
    set_b(1'b1, 1'b0, 13'h0020, 32'h0, 4'h0); tick();
    idle();
    tb_rst = 1'b1;
    tick(); tick();
    tb_rst = 1'b0;
    tick(); tick();

    // Idle after a write: address held, no write strobe or byte enables
    set_a(1'b1, 1'b1, 13'h0100, 32'hCAFEF00D, 4'h3); tick();
    idle(); tick(); tick();

    // Read granted right after a write to the same address sees new data
    set_b(1'b1, 1'b1, 13'h0030, 32'h13579BDF, 4'hF); tick();
    set_b(1'b1, 1'b0, 13'h0030, 32'h0, 4'h0); tick();
    set_b(1'b1, 1'b0, 13'h0100, 32'h0, 4'h0); tick();
    idle(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram2_arbiter.md
# ram2_arbiter

Two-requester arbiter sharing the single-port 8K×32 `ram2` block RAM between instruction fetch (port A) and load/store unit (port B) of the RISC-V core. It grants at most one access per cycle, drives the RAM address/data/byte-enable/write-enable, and routes the one-cycle-latency read data back to the owning requester with a valid strobe.

## Interface
- ADDR_WIDTH, 13, RAM word-address width
- DATA_WIDTH, 32, data width
- BE_WIDTH, 4, byte-enable width (DATA_WIDTH/8)

- clk  in  1  clock, rising edge
- tb_rst  in  1  reset, asynchronous, active-high
- a_req / b_req  in  1  access request; held until granted
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_WIDTH  word address
- a_wdata / b_wdata  in  DATA_WIDTH  write data
- a_be / b_be  in  BE_WIDTH  byte enables (writes only)
- a_gnt / b_gnt  out  1  request accepted this cycle (combinational)
- a_rvalid / b_rvalid  out  1  read data valid (registered)
- a_rdata / b_rdata  out  DATA_WIDTH  read data
- ram_addr  out  ADDR_WIDTH  to ram2 addr
- ram_wr_data  out  DATA_WIDTH  to ram2 wr_data
- ram_wr_byte_en  out  BE_WIDTH  to ram2 wr_byte_en
- ram_wr_en  out  1  to ram2 wr_en
- ram_rd_data  in  DATA_WIDTH  from ram2 rd_data

## Operation
- Handshake: requester asserts req with stable we/addr/wdata/be; transfer occurs in the cycle gnt=1; requester may change fields or drop req the next cycle. No abort: req must not fall before gnt.
- Arbitration each cycle: one req -> that port granted; both -> per policy (see Configuration). No req -> no grant, ram_wr_en=0, ram_addr/ram_wr_data/ram_wr_byte_en hold last granted values (registered copy), ram_wr_byte_en forced 0.
- Granted write: ram_wr_en=1, ram_wr_byte_en=x_be, ram_addr=x_addr, ram_wr_data=x_wdata. No rvalid produced.
- Granted read: ram_wr_en=0, ram_wr_byte_en=0, ram_addr=x_addr.
- Read owner tracking: registered rd_pend (1 bit) and rd_owner (A/B) capture the granted read at the clock edge. While rd_pend=1, x_rvalid=1 for rd_owner, x_rdata=ram_rd_data for owner.
- Non-owner rdata is 0; rdata mux is combinational from ram_rd_data gated by rd_pend/rd_owner.
- Back-to-back reads from either/both ports supported at full rate (one per cycle); write in cycle after read does not disturb returning read data.
- Reset: all registers cleared; a_gnt=b_gnt=0 while tb_rst=1; a_rvalid=b_rvalid=0, a_rdata=b_rdata=0, ram_wr_en=0, ram_wr_byte_en=0, ram_addr=0, ram_wr_data=0, priority pointer = A. Read in flight at reset assertion is discarded (no rvalid after reset release).

## Timing
- Cycle N: req&gnt, RAM signals driven combinationally; RAM samples at end of N.
- Read: x_rvalid and x_rdata valid throughout cycle N+1 (latency 1, OUTPUT_REG=0 RAM).
- Write: committed at end of cycle N; read to same address granted in N+1 returns new data in N+2.
- Throughput: 1 access/cycle total; losing requester waits ≥1 cycle.
- gnt depends combinationally on req and registered state only (no path from ram_rd_data).

## Configuration
- RAM2_ARB_RR_EN defined: round-robin; 1-bit last-grant pointer updated on each grant; on simultaneous req the port not granted last wins. Max wait for a held req = 1 cycle.
- Not defined: fixed priority, port B (load/store) always wins; A may starve while B requests continuously. Pointer logic not synthesized.

## Test plan
- Single A write addr 0x0005 data 0xDEADBEEF be 4'hF, then A read 0x0005 -> a_gnt both cycles, a_rvalid one cycle after read gnt with a_rdata=0xDEADBEEF, b_rvalid=0.
- Byte write B addr 0x1FFF data 0x11223344 be 4'b0101 over 0xFFFFFFFF, read back -> b_rdata=0xFF22FF44.
- A and B read simultaneously (A 0x0010, B 0x0020) for 4 cycles -> RR: grants alternate A,B,A,B (pointer starts A→B wins first? no: pointer=A means A last granted, so B first); fixed: b_gnt every cycle, a_gnt=0; rvalid/rdata always match the granted port's address.
- Back-to-back A reads 0x0000..0x0007 with idle B -> a_gnt every cycle, a_rvalid 8 consecutive cycles, data in address order.
- tb_rst asserted the cycle after a B read grant -> b_rvalid=0 and all RAM outputs 0 immediately; no rvalid after release until new grant.
- Idle (no req) after write to 0x0100 -> ram_wr_en=0, ram_wr_byte_en=0, ram_addr holds 0x0100.
